// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, frame totals and the FSM state type.
// Latency: none, constants and types only.
// Backpressure: none.
package vga_timing_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;
   localparam int COLOR_W_D  = 8;

   // Total period of one axis: active region plus front porch, sync and back porch.
   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int H_TOTAL = axis_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);  // 800
   localparam int V_TOTAL = axis_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);  // 525

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      RESYNC    = 2'd1,
      RUN       = 2'd2
   } state_t;

endpackage

// File: rtl/vga_hv_counter.sv
// vga_hv_counter: horizontal/vertical raster counters with active, hsync and vsync decode.
// Latency: decodes are combinational from the current count; counts advance every clk.
// Backpressure: none; i_clear holds both counters at zero.
// Ports: clk, rst (async, high), i_clear; o_active, o_hs_n, o_vs_n (active-low syncs),
//        o_at_origin (count is (0,0)), o_at_last (count is the last position of the frame).
module vga_hv_counter
   import vga_timing_pkg::*;
#(
   parameter  int H_ACTIVE = H_ACTIVE_D,
   parameter  int H_FP     = H_FP_D,
   parameter  int H_SYNC   = H_SYNC_D,
   parameter  int H_BP     = H_BP_D,
   parameter  int V_ACTIVE = V_ACTIVE_D,
   parameter  int V_FP     = V_FP_D,
   parameter  int V_SYNC   = V_SYNC_D,
   parameter  int V_BP     = V_BP_D
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   output logic o_active,
   output logic o_hs_n,
   output logic o_vs_n,
   output logic o_at_origin,
   output logic o_at_last
);

   localparam int LP_H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int LP_V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW = $clog2(LP_H_TOTAL);
   localparam int VW = $clog2(LP_V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(LP_H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(LP_V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [HW-1:0] r_h_cnt;
   logic [VW-1:0] r_v_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (i_clear) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
      end else begin
         r_h_cnt <= r_h_cnt + HW'(1);
      end
   end

   assign o_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
   assign o_hs_n      = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
   // vsync spans whole lines, so it ignores the horizontal count.
   assign o_vs_n      = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
   assign o_at_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
   assign o_at_last   = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

endmodule

// File: rtl/vga_pixel_timing.sv
// vga_pixel_timing: pixel-clock VGA timing generator that drains a frame-aligned RGB stream to the DAC.
// Latency: all DAC-side outputs are registered, one clk after the counter position they describe.
// Backpressure: in_ready opens on active pixels in RUN; RESYNC drains non-sop beats and holds a sop beat.
// Ports: clk, rst (async, high), pll_locked (async); in_data/in_sop/in_eop/in_valid/in_ready stream sink;
//        vga_r/g/b, vga_hs/vga_vs (active-low), vga_blank_n, vga_sync_n (tied 0); frame_start, underflow pulses.
module vga_pixel_timing
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter int COLOR_W  = COLOR_W_D
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pll_locked,
   input  logic [3*COLOR_W-1:0] in_data,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic                 vga_blank_n,
   output logic                 vga_sync_n,
   output logic                 frame_start,
   output logic                 underflow
);

   logic   r_lock_meta;
   logic   r_lock_s;
   state_t r_state;
   state_t w_state;
   logic   w_idle;
   logic   w_active;
   logic   w_hs_n;
   logic   w_vs_n;
   logic   w_at_origin;
   logic   w_at_last;
   logic   w_sop_head;
   logic   w_show;
   logic   w_err;
   logic   w_in_ready;
   logic   w_unused_eop;

   // End-of-frame is informational only; alignment is judged from sop alone.
   assign w_unused_eop = in_eop;
   assign vga_sync_n   = 1'b0;
   assign in_ready     = w_in_ready;

   // Two-flop synchronizer for the PLL lock, which is asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked;
         r_lock_s    <= r_lock_meta;
      end
   end

   vga_hv_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_hv (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_idle),
      .o_active    (w_active),
      .o_hs_n      (w_hs_n),
      .o_vs_n      (w_vs_n),
      .o_at_origin (w_at_origin),
      .o_at_last   (w_at_last)
   );

   // Losing lock overrides the registered state in the same cycle, so the
   // counters clear and the outputs go idle on the very next edge.
   always_comb begin
      w_state    = r_lock_s ? r_state : WAIT_LOCK;
      w_idle     = !((w_state == RESYNC) || (w_state == RUN));
      w_sop_head = in_valid & in_sop;
      w_in_ready = 1'b0;
      w_show     = 1'b0;
      w_err      = 1'b0;
      case (w_state)
         // Drain anything that is not a frame start; park on the sop beat.
         RESYNC: w_in_ready = !w_sop_head;
         RUN: begin
            if (w_active) begin
               w_in_ready = 1'b1;
               // Good beat: sop exactly at the origin, non-sop everywhere else.
               if (in_valid && (in_sop == w_at_origin)) begin
                  w_show = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= WAIT_LOCK;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else if (w_idle) begin
         r_state     <= r_lock_s ? RESYNC : WAIT_LOCK;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         {vga_r, vga_g, vga_b} <= w_show ? in_data : '0;
         vga_hs      <= w_hs_n;
         vga_vs      <= w_vs_n;
         vga_blank_n <= w_active;
         frame_start <= w_at_origin;
         underflow   <= w_err;
         if (w_err) begin
            r_state <= RESYNC;
         end else if ((w_state == RESYNC) && w_sop_head && w_at_last) begin
            // Enter RUN on the last position so the held sop beat lands on (0,0).
            r_state <= RUN;
         end
      end
   end

endmodule

// File: tb/tb_vga_pixel_timing.sv
module tb_vga_pixel_timing;

   localparam int HT    = 16;
   localparam int VT    = 11;
   localparam int NPIX  = 48;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic [23:0] d;
      logic        sop;
      logic        eop;
   } beat_t;

   typedef struct packed {
      logic [23:0] rgb;
      logic        fs;
      logic        uf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pll_locked;
   logic [23:0] in_data;
   logic        in_sop;
   logic        in_eop;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  vga_r;
   logic [7:0]  vga_g;
   logic [7:0]  vga_b;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank_n;
   logic        vga_sync_n;
   logic        frame_start;
   logic        underflow;

   beat_t src_q[$];
   exp_t  exp_q[$];
   int    checks  = 0;
   int    errors  = 0;
   int    uf_seen = 0;
   int    acc_cnt[8];

   vga_pixel_timing #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
      .COLOR_W  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .in_data     (in_data),
      .in_sop      (in_sop),
      .in_eop      (in_eop),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .vga_sync_n  (vga_sync_n),
      .frame_start (frame_start),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_blank_n"}, vga_blank_n, 0);
      chk({tag, "_hs"}, vga_hs, 1);
      chk({tag, "_vs"}, vga_vs, 1);
      chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_underflow"}, underflow, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
   endtask

   task automatic push_beats(input int tag, input int n, input bit with_sop);
      for (int i = 0; i < n; i++) begin
         beat_t b;
         b.d   = 24'(tag * 1000 + i);
         b.sop = with_sop && (i == 0);
         b.eop = (i == n - 1);
         src_q.push_back(b);
      end
   endtask

   // Displayed pixels of frame tag, indices 0..n-1.
   task automatic exp_disp(input int tag, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.rgb = 24'(tag * 1000 + i);
         e.fs  = (i == 0);
         e.uf  = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   // Black pixels from index 'from' to the end of the frame; underflow at uf_idx.
   task automatic exp_black(input int from, input int uf_idx);
      for (int i = from; i < NPIX; i++) begin
         exp_t e;
         e.rgb = '0;
         e.fs  = (i == 0);
         e.uf  = (i == uf_idx);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_fs(input string name, input int max);
      bit seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s frame_start not seen within %0d cycles (required 1 pulse)", name, max);
      end
   endtask

   task automatic wait_uf(input string name, input int max);
      bit seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (underflow === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s underflow not seen within %0d cycles (required 1 pulse)", name, max);
      end
   endtask

   // Source driver: handshake judged at negedge, next head driven just after posedge.
   initial begin
      bit fire;
      beat_t b;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_data  = '0;
      foreach (acc_cnt[k]) acc_cnt[k] = 0;
      forever begin
         @(negedge clk);
         fire = (in_valid === 1'b1) && (in_ready === 1'b1);
         if (fire && (int'(in_data) / 1000 < 8)) acc_cnt[int'(in_data) / 1000]++;
         @(posedge clk);
         #1;
         if (fire && src_q.size() > 0) b = src_q.pop_front();
         if (src_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = src_q[0].d;
            in_sop   = src_q[0].sop;
            in_eop   = src_q[0].eop;
         end else begin
            in_valid = 1'b0;
            in_sop   = 1'b0;
            in_eop   = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every active output pixel consumes one expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (underflow === 1'b1) uf_seen++;
         if (rst === 1'b0 && vga_blank_n === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_pixel rgb=%0d fs=%0d uf=%0d with no expected entry",
                        {vga_r, vga_g, vga_b}, frame_start, underflow);
            end else begin
               e = exp_q.pop_front();
               chk("sb_rgb", {vga_r, vga_g, vga_b}, e.rgb);
               chk("sb_frame_start", frame_start, e.fs);
               chk("sb_underflow", underflow, e.uf);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      int hs_lo, vs_lo, blank_hi, first_hs, first_vs, n;
      int exp_acc[7];
      exp_acc = '{48, 19, 48, 6, 48, 48, 48};

      rst        = 1'b1;
      pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle("rst");
      chk("rst_sync_n", vga_sync_n, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk_idle("unlocked");

      // Lock rises: two synchronizer edges, one edge in WAIT_LOCK, then RESYNC.
      exp_black(0, -1);
      pll_locked = 1'b1;
      @(negedge clk);
      chk("lock_e1_in_ready", in_ready, 0);
      chk("lock_e1_blank_n", vga_blank_n, 0);
      @(negedge clk);
      chk("lock_e2_in_ready", in_ready, 0);
      chk("lock_e2_blank_n", vga_blank_n, 0);
      @(negedge clk);
      chk("lock_e3_in_ready", in_ready, 1);
      chk("lock_e3_blank_n", vga_blank_n, 0);

      // Frame A in full, frame B stops short before pixel (3,2).
      push_beats(0, NPIX, 1);
      exp_disp(0, NPIX);
      push_beats(1, 19, 1);
      exp_disp(1, 19);
      exp_black(19, 19);

      // Sync geometry over the RESYNC frame, starting at the (0,0) output.
      wait_fs("f0_start", 8);
      hs_lo = 0; vs_lo = 0; blank_hi = 0; first_hs = -1; first_vs = -1;
      for (int i = 0; i < FRAME; i++) begin
         if (vga_hs === 1'b0) begin
            hs_lo++;
            if (first_hs < 0) first_hs = i;
         end
         if (vga_vs === 1'b0) begin
            vs_lo++;
            if (first_vs < 0) first_vs = i;
         end
         if (vga_blank_n === 1'b1) blank_hi++;
         @(negedge clk);
      end
      chk("sync_hs_low_cycles", hs_lo, 3 * VT);
      chk("sync_vs_low_cycles", vs_lo, 2 * HT);
      chk("sync_active_cycles", blank_hi, NPIX);
      chk("sync_first_hs_low", first_hs, 10);
      chk("sync_first_vs_low", first_vs, 7 * HT);
      chk("sync_frame_period", frame_start, 1);

      wait_uf("f2_underflow", 2 * FRAME);
      push_beats(2, NPIX, 1);
      exp_disp(2, NPIX);
      push_beats(3, 6, 0);
      exp_black(0, 0);
      push_beats(4, NPIX, 1);
      exp_disp(4, NPIX);
      push_beats(5, NPIX, 1);
      exp_disp(5, 28);
      push_beats(6, NPIX, 1);
      exp_black(0, -1);
      exp_disp(6, NPIX);

      wait_fs("f3_start", FRAME + 8);
      wait_fs("f4_start", FRAME + 8);
      wait_fs("f5_start", FRAME + 8);
      wait_fs("f6_start", FRAME + 8);
      // Lock drops so that position (4,3) is the first one seen unlocked.
      repeat (49) @(negedge clk);
      pll_locked = 1'b0;
      repeat (10) @(negedge clk);
      chk_idle("lock_lost");
      repeat (20) @(negedge clk);

      pll_locked = 1'b1;
      @(negedge clk);
      chk("relock_e1_in_ready", in_ready, 0);
      @(negedge clk);
      chk("relock_e2_in_ready", in_ready, 0);
      @(negedge clk);
      chk("relock_e3_in_ready", in_ready, 1);

      n = 0;
      while (exp_q.size() != 0 && n < 3 * FRAME) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drained_entries_left", exp_q.size(), 0);
      repeat (20) @(negedge clk);

      for (int t = 0; t < 7; t++) chk($sformatf("accepts_tag%0d", t), acc_cnt[t], exp_acc[t]);
      chk("underflow_pulses", uf_seen, 2);
      chk("source_left", src_q.size(), 0);
      chk("end_sync_n", vga_sync_n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_pixel_timing.md
# vga_pixel_timing

Pixel-clock-domain VGA timing generator and pixel sink for the VGA subsystem. Runs on the 25 MHz pixel clock produced by the video PLL, gates itself on the PLL lock, and consumes a frame-aligned streaming RGB pixel source. It produces registered 640x480@60 Hz RGB, sync and blank signals for the DAC. Underflow and frame misalignment are detected and recovered at the next frame boundary.

## Interface
- H_ACTIVE, 640: active pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal porch and sync widths, in pixels
- V_ACTIVE, 480: active lines per frame
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porch and sync widths, in lines
- COLOR_W, 8: bits per colour channel
- clk  in  1  pixel clock (25 MHz PLL output)
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- in_data  in  3*COLOR_W  pixel {R,G,B}, R in the MSBs
- in_sop  in  1  first pixel of a frame
- in_eop  in  1  last pixel of a frame (informational, not checked)
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- vga_r, vga_g, vga_b  out  COLOR_W each  colour outputs
- vga_hs, vga_vs  out  1 each  sync outputs, active-low
- vga_blank_n  out  1  high during the active region
- vga_sync_n  out  1  constant 0
- frame_start  out  1  one-cycle pulse, aligned with output pixel (0,0)
- underflow  out  1  one-cycle pulse on each misalignment or underflow event

## Operation
- pll_locked passes through a 2-flop synchronizer (locked_s) before any use.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of all H_* parameters, 800) and wraps.
  - v_cnt runs 0..V_TOTAL-1 (V_TOTAL = 525) and increments when h_cnt wraps.
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- State machine:
  - WAIT_LOCK: counters held at 0, in_ready=0, outputs at idle values.
    - Go to RESYNC when locked_s=1.
  - RESYNC: counters run.
    - in_ready=1 and beats with in_sop=0 are discarded.
    - When the head beat has in_valid & in_sop, in_ready=0 and that beat is held.
    - Go to RUN when the counters reach (0,0) with the sop beat held.
  - RUN: in_ready = active.
    - Accepted beat with in_sop=1 at (0,0), or in_sop=0 elsewhere: the beat is displayed.
    - Active cycle with in_valid=0: black pixel, underflow pulse, go to RESYNC.
    - Beat with in_sop=0 at (0,0), or in_sop=1 elsewhere: the beat is consumed and discarded, black pixel, underflow pulse, go to RESYNC.
  - In RESYNC the active region outputs black with vga_blank_n still following the counters.
- Any state: locked_s=0 → WAIT_LOCK within the same cycle. Counters zero and outputs go idle on the next edge.
- Arithmetic:
  - Counter width is $clog2(H_TOTAL) and $clog2(V_TOTAL).
  - Comparisons are unsigned.
  - No saturation; wrap is explicit at TOTAL-1.

## Timing
- Reset values: vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0, underflow=0, in_ready=0, state=WAIT_LOCK, counters=0.
- Outputs are registered, one cycle of latency from the counter value. All outputs for counter position (h,v) appear together on the following edge.
- vga_hs=0 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
- vga_vs=0 for v_cnt in [490,491], for the whole line.
- in_ready is decoded combinationally from state and counters. There is no combinational path from in_valid to in_ready, except the RESYNC hold on in_sop.
- Lock loss mid-frame: the line and frame are truncated with no partial-line recovery. On re-lock the frame restarts from (0,0) via RESYNC.
- rst mid-frame: all state returns to the reset values asynchronously.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants
  - H_TOTAL and V_TOTAL
  - state enum {WAIT_LOCK, RESYNC, RUN}
- Sub-module vga_hv_counter holds h_cnt/v_cnt with the hold/clear input and the active, hsync and vsync decode.
- The synchronizer and FSM live in the top level.

## Test plan
- Reset, then pll_locked rises: locked_s follows 2 edges later. in_ready stays 0 until RESYNC. Outputs hold their reset values throughout.
- Source streams a full frame with in_data = pixel index and in_sop on the first beat: pixel (0,0)=0 appears with frame_start=1 and vga_blank_n=1. Pixel (639,479)=307199 is displayed. There are exactly 307200 accepts per frame.
- Sync check over one frame: hs low for 96 cycles per line starting at count 656, vs low for 1600 cycles, 800 cycles per line, 420000 cycles per frame.
- in_valid dropped at (100,10): that pixel is black and underflow pulses once. The rest of the frame is black. Display resumes at the next frame's (0,0) once a sop beat is supplied.
- Frame starts with a non-sop beat followed by 5 junk beats and then a sop: the first beat is discarded with one underflow pulse. The 5 beats are discarded in RESYNC. Display starts at the next (0,0).
- pll_locked dropped at (320,200), restored 1000 cycles later: outputs go idle and counters reset. Normal display resumes one full RESYNC frame later.
